// File: rtl/writeback_unit.sv
// =============================================================================
// writeback_unit
// -----------------------------------------------------------------------------
// Write side of the CPU register file. Retired results (instruction + data)
// from execute/memory are buffered in a small FIFO. Each writing result is then
// presented to the level-sensitive register file with a setup / strobe /
// release sequence. This keeps rf_instr/rf_data stable whenever
// rf_enable_write is high. The read window (rf_enable_read) is open only while
// no write is in flight.
//
// Parameters
//   DEPTH  FIFO entries (power of 2, >= 2)
//   CNT_W  width of retire_count / write_count
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   asynchronous, active-high reset
//   in_valid         in   result offered
//   in_instr[31:0]   in   retired instruction: opcode [31:27], rd [26:22]
//   in_data[31:0]    in   result value
//   in_ready         out  FIFO can accept (transfer on in_valid & in_ready)
//   rf_instr[31:0]   out  instruction presented to the register file
//   rf_data[31:0]    out  data presented to the register file
//   rf_enable_write  out  register-file write strobe (one cycle per write)
//   rf_enable_read   out  register-file read window
//   busy             out  sequencer active or FIFO non-empty
//   retire_count     out  number of entries popped (wraps)
//   write_count      out  number of entries that produced a strobe (wraps)
//   qry_addr[4:0]    in   hazard query register index
//   qry_hit          out  pending write to qry_addr
//
// Configuration macro
//   WB_FORWARD_EN  when defined, qry_hit reports whether any queued entry or
//                  the entry in SETUP/STROBE is a writing op targeting
//                  qry_addr. When undefined, qry_hit is tied low.
// =============================================================================
module writeback_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [31:0]      rf_instr,
    output logic [31:0]      rf_data,
    output logic             rf_enable_write,
    output logic             rf_enable_read,
    output logic             busy,
    output logic [CNT_W-1:0] retire_count,
    output logic [CNT_W-1:0] write_count,
    input  logic [4:0]       qry_addr,
    output logic             qry_hit
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        STROBE  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Writing opcodes: LW(0), MOV(2), ADD..DIV(3-6), AND(7), OR(8), SHL(9),
    // SHR(10), NOT(12). Everything else retires without touching the file.
    function automatic logic isWriting(input logic [4:0] op);
        return ((op <= 5'd10) && (op != 5'd1)) || (op == 5'd12);
    endfunction

    logic [31:0]      fifoInstr_q [DEPTH];
    logic [31:0]      fifoData_q  [DEPTH];
    logic [PTR_W-1:0] rdPtr_q, wrPtr_q;
    logic [CW-1:0]    count_q, count_d;

    state_t           state_q;
    logic [31:0]      rfInstr_q, rfData_q;
    logic             rfWe_q, rfRe_q;
    logic [CNT_W-1:0] retireCount_q, writeCount_q;

    logic             push, pop, headValid, headWriting;
    logic [31:0]      headInstr, headData;

    assign headValid   = (count_q != '0);
    assign headInstr   = fifoInstr_q[rdPtr_q];
    assign headData    = fifoData_q[rdPtr_q];
    assign headWriting = isWriting(headInstr[31:27]);

    // The sequencer only takes a new entry in IDLE or RELEASE; every entry it
    // looks at is consumed there, writing or not.
    assign in_ready = (count_q != FULL_COUNT);
    assign push     = in_valid && in_ready;
    assign pop      = headValid && ((state_q == IDLE) || (state_q == RELEASE));

    assign rf_instr        = rfInstr_q;
    assign rf_data         = rfData_q;
    assign rf_enable_write = rfWe_q;
    assign rf_enable_read  = rfRe_q;
    assign retire_count    = retireCount_q;
    assign write_count     = writeCount_q;
    assign busy            = (state_q != IDLE) || headValid;

    // FIFO storage needs no reset: only entries below count_q are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoInstr_q[wrPtr_q] <= in_instr;
            fifoData_q[wrPtr_q]  <= in_data;
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
        end
    end

    // Write sequencer. rf_instr/rf_data load only on edges entering SETUP, so
    // they are settled a full cycle before the strobe and held through RELEASE.
    // The counters advance on the edge leaving STROBE for writes, and on the
    // popping edge for non-writing entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rfInstr_q     <= '0;
            rfData_q      <= '0;
            rfWe_q        <= 1'b0;
            rfRe_q        <= 1'b1;
            retireCount_q <= '0;
            writeCount_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (headValid) begin
                        if (headWriting) begin
                            rfInstr_q <= headInstr;
                            rfData_q  <= headData;
                            rfRe_q    <= 1'b0;
                            state_q   <= SETUP;
                        end else begin
                            retireCount_q <= retireCount_q + CNT_W'(1);
                        end
                    end
                end
                SETUP: begin
                    rfWe_q  <= 1'b1;
                    state_q <= STROBE;
                end
                STROBE: begin
                    rfWe_q        <= 1'b0;
                    writeCount_q  <= writeCount_q + CNT_W'(1);
                    retireCount_q <= retireCount_q + CNT_W'(1);
                    state_q       <= RELEASE;
                end
                RELEASE: begin
                    if (headValid && headWriting) begin
                        rfInstr_q <= headInstr;
                        rfData_q  <= headData;
                        state_q   <= SETUP;
                    end else begin
                        if (headValid) begin
                            retireCount_q <= retireCount_q + CNT_W'(1);
                        end
                        rfRe_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    rfWe_q  <= 1'b0;
                    rfRe_q  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef WB_FORWARD_EN
    // Hazard query: scan the occupied FIFO slots, oldest first, plus the entry
    // being written. Only writing entries are ever loaded into rf_instr, so the
    // in-flight check needs no opcode test. In RELEASE the write is complete.
    logic [PTR_W-1:0] fwdIdx;

    always_comb begin
        qry_hit = 1'b0;
        fwdIdx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwdIdx = rdPtr_q + PTR_W'(i);
            if ((CW'(i) < count_q) &&
                isWriting(fifoInstr_q[fwdIdx][31:27]) &&
                (fifoInstr_q[fwdIdx][26:22] == qry_addr)) begin
                qry_hit = 1'b1;
            end
        end
        if (((state_q == SETUP) || (state_q == STROBE)) &&
            (rfInstr_q[26:22] == qry_addr)) begin
            qry_hit = 1'b1;
        end
    end
`else
    logic unusedQry;

    assign unusedQry = ^qry_addr;
    assign qry_hit   = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// =============================================================================
// tb_writeback_unit
// Directed and randomized stimulus for writeback_unit. A reference model
// (expected strobe list and retire/write tallies) is built from the opcode
// rules as results are pushed. A negedge monitor records every write strobe.
// =============================================================================
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] rf_instr;
    logic [31:0] rf_data;
    logic        rf_enable_write;
    logic        rf_enable_read;
    logic        busy;
    logic [15:0] retire_count;
    logic [15:0] write_count;
    logic [4:0]  qry_addr;
    logic        qry_hit;

    writeback_unit #(.DEPTH(4), .CNT_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_instr        (in_instr),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .rf_instr        (rf_instr),
        .rf_data         (rf_data),
        .rf_enable_write (rf_enable_write),
        .rf_enable_read  (rf_enable_read),
        .busy            (busy),
        .retire_count    (retire_count),
        .write_count     (write_count),
        .qry_addr        (qry_addr),
        .qry_hit         (qry_hit)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    logic [31:0] writeMask = 32'h0000_17FD;
    int          writingOps[11] = '{0, 2, 3, 4, 5, 6, 7, 8, 9, 10, 12};
    int          expRetire = 0;
    int          expWrite  = 0;
    logic [31:0] expInstr[$];
    logic [31:0] expData[$];
    logic        fwdOn;

    // Strobe monitor, sampled on the falling edge.
    int          cycle = 0;
    logic        prevWe = 1'b0;
    logic [31:0] prevInstr = '0;
    logic [31:0] prevData = '0;
    int          strobeCycle[$];
    logic [31:0] strobeInstr[$];
    logic [31:0] strobeData[$];
    int          longPulses = 0;
    int          unstableWrites = 0;
    int          readDuringWrite = 0;
    bit          sawNotReady = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (rf_enable_write === 1'b1) begin
            if (prevWe) begin
                longPulses++;
            end else begin
                strobeCycle.push_back(cycle);
                strobeInstr.push_back(rf_instr);
                strobeData.push_back(rf_data);
            end
            if (rf_instr !== prevInstr || rf_data !== prevData) unstableWrites++;
            if (rf_enable_read !== 1'b0) readDuringWrite++;
        end
        if (in_ready === 1'b0) sawNotReady = 1'b1;
        prevWe    = (rf_enable_write === 1'b1);
        prevInstr = rf_instr;
        prevData  = rf_data;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one result and hold it until the DUT takes it. Called and returns
    // 1 time unit after a rising edge; the model is updated on acceptance.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] data);
        int   budget;
        logic ready;
        logic done;
        budget   = 64;
        done     = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        in_data  = data;
        while (!done && budget > 0) begin
            ready = in_ready;
            @(posedge clk);
            #1;
            if (ready) done = 1'b1;
            budget--;
        end
        in_valid = 1'b0;
        if (!done) begin
            checkOutput("push_timeout", {31'b0, done}, 32'd1);
        end else begin
            expRetire++;
            if (writeMask[instr[31:27]]) begin
                expWrite++;
                expInstr.push_back(instr);
                expData.push_back(data);
            end
        end
    endtask

    task automatic waitIdle(input string tag);
        int budget;
        budget = 200;
        while (busy !== 1'b0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        checkOutput(tag, {31'b0, busy}, 32'd0);
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_retire"}, {16'b0, retire_count}, expRetire & 32'hFFFF);
        checkOutput({tag, "_write"},  {16'b0, write_count},  expWrite & 32'hFFFF);
    endtask

    // Compare the captured strobes against the model's expected list.
    task automatic checkStrobes(input string tag);
        int n;
        checkOutput({tag, "_nstrobes"}, strobeInstr.size(), expInstr.size());
        n = (strobeInstr.size() < expInstr.size()) ? strobeInstr.size() : expInstr.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_instr%0d", tag, i), strobeInstr[i], expInstr[i]);
            checkOutput($sformatf("%s_data%0d", tag, i), strobeData[i], expData[i]);
        end
    endtask

    task automatic clearLogs();
        expInstr.delete();
        expData.delete();
        strobeCycle.delete();
        strobeInstr.delete();
        strobeData.delete();
    endtask

    function automatic logic [31:0] makeInstr(input int op, input int rd);
        return (32'(op) << 27) | (32'(rd & 31) << 22) | ($urandom() & 32'h003F_FFFF);
    endfunction

    initial begin
        int          op;
        int          budget;
        int          transfers;
        logic        ready;
        logic [31:0] d;

`ifdef WB_FORWARD_EN
        fwdOn = 1'b1;
`else
        fwdOn = 1'b0;
`endif
        reset    = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        in_data  = '0;
        qry_addr = '0;
        waitCycles(3);

        // Reset state.
        checkOutput("rst_rf_instr", rf_instr, 32'h0);
        checkOutput("rst_rf_data", rf_data, 32'h0);
        checkOutput("rst_we", {31'b0, rf_enable_write}, 32'd0);
        checkOutput("rst_re", {31'b0, rf_enable_read}, 32'd1);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_qry_hit", {31'b0, qry_hit}, 32'd0);
        checkCounters("rst");
        @(negedge clk);
        reset = 1'b0;
        waitCycles(2);

        // Single ADD rd=5: strobe in the cycle after N+2, idle by N+4.
        applyStimulus(32'h1940_0000, 32'h0000_1234);
        checkOutput("t1_n0_busy", {31'b0, busy}, 32'd1);
        checkOutput("t1_n0_re", {31'b0, rf_enable_read}, 32'd1);
        waitCycles(1);
        checkOutput("t1_n1_we", {31'b0, rf_enable_write}, 32'd0);
        checkOutput("t1_n1_re", {31'b0, rf_enable_read}, 32'd0);
        checkOutput("t1_n1_instr", rf_instr, 32'h1940_0000);
        checkOutput("t1_n1_data", rf_data, 32'h0000_1234);
        waitCycles(1);
        checkOutput("t1_n2_we", {31'b0, rf_enable_write}, 32'd1);
        waitCycles(1);
        checkOutput("t1_n3_we", {31'b0, rf_enable_write}, 32'd0);
        checkCounters("t1_n3");
        waitCycles(1);
        checkOutput("t1_n4_busy", {31'b0, busy}, 32'd0);
        checkOutput("t1_n4_re", {31'b0, rf_enable_read}, 32'd1);
        checkStrobes("t1");

        // SW then CMP: retired without any strobe.
        applyStimulus(32'h0800_0000, $urandom());
        applyStimulus(32'h5800_0000, $urandom());
        waitIdle("t2_idle");
        checkCounters("t2");
        checkStrobes("t2");
        checkOutput("t2_rf_instr_held", rf_instr, 32'h1940_0000);

        // Back-to-back writing results: FIFO fills, strobes 3 cycles apart.
        clearLogs();
        sawNotReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(makeInstr(writingOps[$urandom_range(0, 10)], $urandom_range(0, 31)),
                          $urandom());
        end
        waitIdle("t3_idle");
        checkOutput("t3_saw_not_ready", {31'b0, sawNotReady}, 32'd1);
        checkStrobes("t3");
        for (int i = 1; i < strobeCycle.size(); i++) begin
            checkOutput($sformatf("t3_cadence%0d", i), strobeCycle[i] - strobeCycle[i-1], 32'd3);
        end
        checkCounters("t3");

        // Hazard query on a queued LW rd=2.
        clearLogs();
        qry_addr = 5'd2;
        applyStimulus(32'h0080_0000, $urandom());
        checkOutput("t5_queued_hit", {31'b0, qry_hit}, {31'b0, fwdOn});
        waitCycles(1);
        checkOutput("t5_setup_hit", {31'b0, qry_hit}, {31'b0, fwdOn});
        qry_addr = 5'd3;
        #1;
        checkOutput("t5_setup_other", {31'b0, qry_hit}, 32'd0);
        qry_addr = 5'd2;
        waitCycles(1);
        checkOutput("t5_strobe_we", {31'b0, rf_enable_write}, 32'd1);
        checkOutput("t5_strobe_hit", {31'b0, qry_hit}, {31'b0, fwdOn});
        waitCycles(1);
        checkOutput("t5_release_hit", {31'b0, qry_hit}, 32'd0);
        waitIdle("t5_idle");
        checkStrobes("t5");

        // Randomized mix of opcodes and gaps.
        clearLogs();
        for (int i = 0; i < 24; i++) begin
            op = $urandom_range(0, 31);
            applyStimulus(makeInstr(op, $urandom_range(0, 31)), $urandom());
            if ($urandom_range(0, 2) == 0) waitCycles($urandom_range(1, 4));
        end
        waitIdle("rnd_idle");
        checkStrobes("rnd");
        checkCounters("rnd");

        // Reset in the middle of a strobe with a second entry still queued.
        applyStimulus(32'h1940_0000, 32'hAAAA_5555);
        applyStimulus(32'h2000_0000, 32'h5555_AAAA);
        budget = 20;
        while (rf_enable_write !== 1'b1 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        checkOutput("t4_reach_strobe", {31'b0, rf_enable_write}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        expRetire = 0;
        expWrite  = 0;
        checkOutput("t4_we", {31'b0, rf_enable_write}, 32'd0);
        checkOutput("t4_re", {31'b0, rf_enable_read}, 32'd1);
        checkOutput("t4_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("t4_busy", {31'b0, busy}, 32'd0);
        checkCounters("t4");
        @(negedge clk);
        reset = 1'b0;
        waitCycles(2);
        checkOutput("t4_post_busy", {31'b0, busy}, 32'd0);

        // Counter wrap: 65535 SW results, then one more.
        clearLogs();
        in_valid  = 1'b1;
        in_instr  = 32'h0800_0000;
        in_data   = '0;
        transfers = 0;
        budget    = 70000;
        while (transfers < 65535 && budget > 0) begin
            ready = in_ready;
            @(posedge clk);
            #1;
            if (ready) transfers++;
            budget--;
        end
        in_valid = 1'b0;
        checkOutput("t6_transfers", transfers, 32'd65535);
        expRetire += transfers;
        waitIdle("t6_idle");
        checkCounters("t6_full");
        d = $urandom();
        applyStimulus(32'h0800_0000, d);
        waitIdle("t6_wrap_idle");
        checkCounters("t6_wrap");

        // Whole-run properties gathered by the monitor.
        checkOutput("long_pulses", longPulses, 32'd0);
        checkOutput("unstable_writes", unstableWrites, 32'd0);
        checkOutput("read_during_write", readDuringWrite, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
